// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32 controller: state type,
// immediate-format codes, opcodes, ALU-op and datapath mux encodings,
// plus the branch-condition helpers.
package mc_control_fsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXER, S_EXEI,
      S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_TRAP
   } state_t;

   // Legacy 2-bit immediate codes are the low bits of these.
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_B = 3'b001;
   localparam logic [2:0] IMM_S = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   function automatic logic branch_ok(input logic [2:0] f3);
      return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
   endfunction

   function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                         input logic lt);
      case (f3)
         3'b000:  return zero;
         3'b001:  return !zero;
         3'b100:  return lt;
         3'b101:  return !lt;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath bundle.
//   slave  : controller side (instruction fields, ALU flags, mem_ready in;
//            all select/enable strobes, illegal, state_o out)
//   master : datapath/memory side (mirror directions)
interface mc_control_fsm_if #(parameter int IMMSRC_W = 3);
   logic [6:0]          op;
   logic [2:0]          funct3;
   logic                funct7b5;
   logic                zero;
   logic                lt;
   logic                mem_ready;
   logic                mem_req;
   logic                pc_write;
   logic                adr_src;
   logic                mem_write;
   logic                ir_write;
   logic [1:0]          result_src;
   logic [1:0]          alu_src_a;
   logic [1:0]          alu_src_b;
   logic [1:0]          alu_op;
   logic [IMMSRC_W-1:0] imm_src;
   logic                reg_write;
   logic                illegal;
   logic [3:0]          state_o;

   modport slave (
      input  op, funct3, funct7b5, zero, lt, mem_ready,
      output mem_req, pc_write, adr_src, mem_write, ir_write, result_src,
             alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal, state_o
   );

   modport master (
      output op, funct3, funct7b5, zero, lt, mem_ready,
      input  mem_req, pc_write, adr_src, mem_write, ir_write, result_src,
             alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal, state_o
   );
endinterface

// File: rtl/mc_control_fsm_imm_src_dec.sv
// Combinational opcode -> immediate-format decoder (3-bit, adds U-type).
//   op      in  7  instruction opcode
//   imm_sel out 3  IMM_I/B/S/J/U
module imm_src_dec
   import mc_control_fsm_pkg::*;
(
   input  logic [6:0] op,
   output logic [2:0] imm_sel
);
   always_comb begin
      case (op)
         OP_STORE:         imm_sel = IMM_S;
         OP_BRANCH:        imm_sel = IMM_B;
         OP_JAL:           imm_sel = IMM_J;
         OP_LUI, OP_AUIPC: imm_sel = IMM_U;
         default:          imm_sel = IMM_I;
      endcase
   end
endmodule

// File: rtl/mc_control_fsm.sv
// Main controller for the multi-cycle RV32 datapath.
//   clk   in   rising-edge clock
//   reset in   asynchronous, active-high
//   bus   slave modport of mc_control_fsm_if: instruction fields, ALU flags
//         and mem_ready in; datapath selects/enables, sticky illegal and
//         state_o out. Outputs are decoded combinationally from the state.
module mc_control_fsm
   import mc_control_fsm_pkg::*;
#(
   parameter int IMMSRC_W = 3,
   parameter bit EN_UTYPE = 1'b1,
   parameter bit MEM_WAIT = 1'b1
) (
   input logic           clk,
   input logic           reset,
   mc_control_fsm_if.slave bus
);

   state_t     state, state_next;
   logic       ready;
   logic [2:0] imm_dec, imm_sel;
   logic       unused;

   // funct7b5 only matters to the ALU decoder downstream.
   assign unused = bus.funct7b5;

   assign ready = MEM_WAIT ? bus.mem_ready : 1'b1;

   imm_src_dec u_imm_dec (
      .op      (bus.op),
      .imm_sel (imm_dec)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_FETCH;
         bus.illegal <= 1'b0;
      end else begin
         state <= state_next;
         if (state == S_TRAP || (state == S_BRANCH && !branch_ok(bus.funct3)))
            bus.illegal <= 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:  if (ready) state_next = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_RTYPE:          state_next = S_EXER;
               OP_ITYPE:          state_next = S_EXEI;
               OP_BRANCH:         state_next = S_BRANCH;
               OP_JAL:            state_next = S_JAL;
               OP_JALR:           state_next = S_JALR;
               OP_LUI:            state_next = EN_UTYPE ? S_LUI : S_TRAP;
               OP_AUIPC:          state_next = EN_UTYPE ? S_AUIPC : S_TRAP;
               default:           state_next = S_TRAP;
            endcase
         end
         S_MEMADR: state_next = (bus.op == OP_STORE) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (ready) state_next = S_MEMWB;
         S_MEMWR:  if (ready) state_next = S_FETCH;
         S_MEMWB, S_ALUWB, S_BRANCH: state_next = S_FETCH;
         S_EXER, S_EXEI, S_JAL, S_JALR, S_LUI, S_AUIPC: state_next = S_ALUWB;
         default:  state_next = S_TRAP;
      endcase
   end

   always_comb begin
      bus.mem_req    = 1'b0;
      bus.pc_write   = 1'b0;
      bus.adr_src    = 1'b0;
      bus.mem_write  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.result_src = RES_ALUOUT;
      bus.alu_src_a  = SRCA_PC;
      bus.alu_src_b  = SRCB_RS2;
      bus.alu_op     = ALU_ADD;
      bus.reg_write  = 1'b0;
      imm_sel        = IMM_I;
      case (state)
         S_FETCH: begin
            bus.mem_req    = 1'b1;
            bus.alu_src_b  = SRCB_FOUR;
            bus.result_src = RES_ALURES;
            bus.ir_write   = ready && !reset;
            bus.pc_write   = ready && !reset;
         end
         S_DECODE: begin
            // Branch target is precomputed here into ALUOut.
            bus.alu_src_a = SRCA_OLDPC;
            bus.alu_src_b = SRCB_IMM;
            imm_sel       = IMM_B;
         end
         S_MEMADR: begin
            bus.alu_src_a = SRCA_RS1;
            bus.alu_src_b = SRCB_IMM;
            imm_sel       = imm_dec;
         end
         S_MEMRD: begin
            bus.mem_req = 1'b1;
            bus.adr_src = 1'b1;
         end
         S_MEMWR: begin
            bus.mem_req   = 1'b1;
            bus.adr_src   = 1'b1;
            bus.mem_write = !reset;
         end
         S_MEMWB: begin
            bus.result_src = RES_DATA;
            bus.reg_write  = 1'b1;
         end
         S_EXER: begin
            bus.alu_src_a = SRCA_RS1;
            bus.alu_op    = ALU_FUNCT;
         end
         S_EXEI: begin
            bus.alu_src_a = SRCA_RS1;
            bus.alu_src_b = SRCB_IMM;
            bus.alu_op    = ALU_FUNCT;
            imm_sel       = imm_dec;
         end
         S_ALUWB: begin
            bus.reg_write = 1'b1;
            // After JALR, ALUOut holds the jump target, so the link value
            // OldPC+4 is recomputed and taken straight from the ALU.
            if (bus.op == OP_JALR) begin
               bus.alu_src_a  = SRCA_OLDPC;
               bus.alu_src_b  = SRCB_FOUR;
               bus.result_src = RES_ALURES;
            end
         end
         S_BRANCH: begin
            bus.alu_src_a = SRCA_RS1;
            bus.alu_op    = ALU_SUB;
            bus.pc_write  = branch_taken(bus.funct3, bus.zero, bus.lt);
         end
         S_JAL: begin
            bus.alu_src_a = SRCA_OLDPC;
            bus.alu_src_b = SRCB_FOUR;
            bus.pc_write  = 1'b1;
         end
         S_JALR: begin
            bus.alu_src_a  = SRCA_RS1;
            bus.alu_src_b  = SRCB_IMM;
            bus.result_src = RES_ALURES;
            bus.pc_write   = 1'b1;
            imm_sel        = imm_dec;
         end
         S_LUI: begin
            bus.alu_src_a = SRCA_ZERO;
            bus.alu_src_b = SRCB_IMM;
            imm_sel       = imm_dec;
         end
         S_AUIPC: begin
            bus.alu_src_a = SRCA_OLDPC;
            bus.alu_src_b = SRCB_IMM;
            imm_sel       = imm_dec;
         end
         default: ;
      endcase
   end

   assign bus.imm_src = imm_sel[IMMSRC_W-1:0];
   assign bus.state_o = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: one instance with U-type enabled and
// one with EN_UTYPE=0 fed a lui to exercise the trap path.
module tb_mc_control_fsm;
   import mc_control_fsm_pkg::*;

   logic clk;
   logic reset;
   logic rst_b;
   int   n_checks = 0;
   int   n_fail   = 0;

   mc_control_fsm_if #(.IMMSRC_W(3)) if_a ();
   mc_control_fsm_if #(.IMMSRC_W(3)) if_b ();

   mc_control_fsm #(.IMMSRC_W(3), .EN_UTYPE(1'b1), .MEM_WAIT(1'b1)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (if_a)
   );

   mc_control_fsm #(.IMMSRC_W(3), .EN_UTYPE(1'b0), .MEM_WAIT(1'b1)) u_dut_nu (
      .clk   (clk),
      .reset (rst_b),
      .bus   (if_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic run_branch(input logic [2:0] f3, input logic z, input logic l,
                             input logic exp_taken);
      if_a.op     = OP_BRANCH;
      if_a.funct3 = f3;
      if_a.zero   = z;
      if_a.lt     = l;
      tick();
      check("br_decode", if_a.state_o, S_DECODE);
      tick();
      check("br_state", if_a.state_o, S_BRANCH);
      check("br_aluop", if_a.alu_op, 2'b01);
      check("br_pcwrite", if_a.pc_write, exp_taken);
      check("br_regwrite", if_a.reg_write, 1'b0);
      tick();
      check("br_back_fetch", if_a.state_o, S_FETCH);
   endtask

   // Main instance
   initial begin
      reset          = 1'b1;
      if_a.op        = OP_ITYPE;
      if_a.funct3    = 3'b000;
      if_a.funct7b5  = 1'b0;
      if_a.zero      = 1'b0;
      if_a.lt        = 1'b0;
      if_a.mem_ready = 1'b1;
      tick();
      check("rst_state", if_a.state_o, S_FETCH);
      check("rst_irwrite", if_a.ir_write, 1'b0);
      check("rst_pcwrite", if_a.pc_write, 1'b0);
      check("rst_memwrite", if_a.mem_write, 1'b0);
      check("rst_srcb", if_a.alu_src_b, 2'b10);
      check("rst_illegal", if_a.illegal, 1'b0);
      tick();
      reset = 1'b0;
      #1;

      // addi x1,x0,5
      check("addi_fetch", if_a.state_o, S_FETCH);
      check("addi_fetch_ir", if_a.ir_write, 1'b1);
      check("addi_fetch_pc", if_a.pc_write, 1'b1);
      check("addi_fetch_req", if_a.mem_req, 1'b1);
      check("addi_fetch_rw", if_a.reg_write, 1'b0);
      tick();
      check("addi_decode", if_a.state_o, S_DECODE);
      check("addi_decode_imm", if_a.imm_src, 3'b001);
      check("addi_decode_a", if_a.alu_src_a, 2'b01);
      check("addi_decode_rw", if_a.reg_write, 1'b0);
      tick();
      check("addi_exei", if_a.state_o, S_EXEI);
      check("addi_exei_imm", if_a.imm_src, 3'b000);
      check("addi_exei_a", if_a.alu_src_a, 2'b10);
      check("addi_exei_b", if_a.alu_src_b, 2'b01);
      check("addi_exei_aluop", if_a.alu_op, 2'b10);
      check("addi_exei_rw", if_a.reg_write, 1'b0);
      tick();
      check("addi_aluwb", if_a.state_o, S_ALUWB);
      check("addi_aluwb_rw", if_a.reg_write, 1'b1);
      check("addi_aluwb_res", if_a.result_src, 2'b00);
      tick();
      check("addi_done", if_a.state_o, S_FETCH);

      // lw with three wait cycles in MEMRD
      if_a.op = OP_LOAD;
      tick();
      tick();
      check("lw_memadr", if_a.state_o, S_MEMADR);
      check("lw_memadr_imm", if_a.imm_src, 3'b000);
      if_a.mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         check("lw_memrd_hold", if_a.state_o, S_MEMRD);
         check("lw_memrd_req", if_a.mem_req, 1'b1);
         check("lw_memrd_adr", if_a.adr_src, 1'b1);
         check("lw_memrd_rw", if_a.reg_write, 1'b0);
         tick();
      end
      if_a.mem_ready = 1'b1;
      #1;
      check("lw_memrd_last", if_a.state_o, S_MEMRD);
      tick();
      check("lw_memwb", if_a.state_o, S_MEMWB);
      check("lw_memwb_rw", if_a.reg_write, 1'b1);
      check("lw_memwb_res", if_a.result_src, 2'b01);
      tick();
      check("lw_done", if_a.state_o, S_FETCH);

      // Branches
      run_branch(3'b000, 1'b1, 1'b0, 1'b1);
      run_branch(3'b000, 1'b0, 1'b0, 1'b0);
      run_branch(3'b001, 1'b0, 1'b0, 1'b1);
      run_branch(3'b001, 1'b1, 1'b0, 1'b0);
      run_branch(3'b100, 1'b0, 1'b1, 1'b1);
      run_branch(3'b101, 1'b0, 1'b1, 1'b0);
      check("br_no_illegal", if_a.illegal, 1'b0);

      // lui
      if_a.op = OP_LUI;
      tick();
      tick();
      check("lui_state", if_a.state_o, S_LUI);
      check("lui_imm", if_a.imm_src, 3'b100);
      check("lui_a", if_a.alu_src_a, 2'b11);
      check("lui_b", if_a.alu_src_b, 2'b01);
      tick();
      check("lui_aluwb_rw", if_a.reg_write, 1'b1);
      tick();

      // jalr
      if_a.op = OP_JALR;
      tick();
      tick();
      check("jalr_state", if_a.state_o, S_JALR);
      check("jalr_pcwrite", if_a.pc_write, 1'b1);
      check("jalr_res", if_a.result_src, 2'b10);
      check("jalr_a", if_a.alu_src_a, 2'b10);
      tick();
      check("jalr_aluwb", if_a.state_o, S_ALUWB);
      check("jalr_aluwb_a", if_a.alu_src_a, 2'b01);
      check("jalr_aluwb_b", if_a.alu_src_b, 2'b10);
      check("jalr_aluwb_res", if_a.result_src, 2'b10);
      check("jalr_aluwb_rw", if_a.reg_write, 1'b1);
      tick();
      check("jalr_done", if_a.state_o, S_FETCH);

      // sw
      if_a.op = OP_STORE;
      tick();
      check("sw_decode_mw", if_a.mem_write, 1'b0);
      tick();
      check("sw_memadr", if_a.state_o, S_MEMADR);
      check("sw_memadr_imm", if_a.imm_src, 3'b010);
      check("sw_memadr_mw", if_a.mem_write, 1'b0);
      check("sw_memadr_rw", if_a.reg_write, 1'b0);
      tick();
      check("sw_memwr", if_a.state_o, S_MEMWR);
      check("sw_memwr_mw", if_a.mem_write, 1'b1);
      check("sw_memwr_rw", if_a.reg_write, 1'b0);
      tick();
      check("sw_done", if_a.state_o, S_FETCH);
      check("sw_done_mw", if_a.mem_write, 1'b0);

      // Unsupported branch funct3 sets sticky illegal
      run_branch(3'b010, 1'b1, 1'b1, 1'b0);
      check("badbr_illegal", if_a.illegal, 1'b1);
      tick();
      check("badbr_sticky", if_a.illegal, 1'b1);

      // Reset in the middle of a stalled store
      if_a.op = OP_STORE;
      tick();
      tick();
      if_a.mem_ready = 1'b0;
      tick();
      check("swst_memwr_mw", if_a.mem_write, 1'b1);
      tick();
      check("swst_hold", if_a.state_o, S_MEMWR);
      #2;
      reset = 1'b1;
      #1;
      check("swst_rst_state", if_a.state_o, S_FETCH);
      check("swst_rst_mw", if_a.mem_write, 1'b0);
      check("swst_rst_illegal", if_a.illegal, 1'b0);
      tick();
      reset          = 1'b0;
      if_a.mem_ready = 1'b1;
      if_a.op        = OP_ITYPE;
      #1;
      check("post_rst_fetch", if_a.state_o, S_FETCH);
      check("post_rst_ir", if_a.ir_write, 1'b1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // EN_UTYPE=0 instance: lui must trap
   initial begin
      rst_b          = 1'b1;
      if_b.op        = OP_LUI;
      if_b.funct3    = 3'b000;
      if_b.funct7b5  = 1'b0;
      if_b.zero      = 1'b0;
      if_b.lt        = 1'b0;
      if_b.mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_b = 1'b0;
      #1;
      check("nu_fetch", if_b.state_o, S_FETCH);
      @(negedge clk);
      #1;
      check("nu_decode", if_b.state_o, S_DECODE);
      @(negedge clk);
      #1;
      check("nu_trap", if_b.state_o, S_TRAP);
      check("nu_trap_req", if_b.mem_req, 1'b0);
      @(negedge clk);
      #1;
      check("nu_illegal", if_b.illegal, 1'b1);
      repeat (3) @(negedge clk);
      #1;
      check("nu_trap_hold", if_b.state_o, S_TRAP);
      check("nu_illegal_sticky", if_b.illegal, 1'b1);
      check("nu_trap_rw", if_b.reg_write, 1'b0);
      check("nu_trap_pc", if_b.pc_write, 1'b0);
   end

endmodule
